// File: rtl/conv_layer_scheduler.sv
// Multi-layer convolution sequencer: per layer runs weight load, bias load and compute,
// with per-layer beat targets read from a small writable config table.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; layer_idx holds the last layer run
// LOAD_W  | counting DDR_valid_in beats up to the layer's weight target
// LOAD_B  | fixed-length bias load of BIAS_CYCLES cycles
// COMPUTE | counting MAC_data_valid_out beats up to the compute target
// NEXT    | one-cycle decision: advance to the next layer or finish
// DONE    | one-cycle completion pulse
module conv_layer_scheduler #(
    parameter int  LAYER_NUM   = 8,
    parameter int  CNT_WIDTH   = 16,
    parameter int  BIAS_CYCLES = 9,
    localparam int LW          = $clog2(LAYER_NUM)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [LW:0]            cfg_layer_num,
    input  logic                   cfg_wr_en,
    input  logic [LW-1:0]          cfg_wr_addr,
    input  logic [2*CNT_WIDTH-1:0] cfg_wr_data,
    input  logic                   DDR_valid_in,
    input  logic                   MAC_data_valid_out,
    output logic [2:0]             current_state,
    output logic                   state_rst,
    output logic [LW-1:0]          layer_idx,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_B  = 3'd2,
        COMPUTE = 3'd3,
        NEXT    = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] BIAS_LAST = CNT_WIDTH'(BIAS_CYCLES - 1);
    localparam logic [LW:0]          LAYER_MAX = (LW+1)'(LAYER_NUM);

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_state_rst;
    logic                   r_busy;
    logic                   r_done;
    logic [LW-1:0]          r_idx;
    logic [LW-1:0]          w_idx_next;
    logic [LW:0]            r_num;
    logic [LW:0]            w_num_clamp;
    logic                   w_latch_num;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;
    logic                   w_cnt_en;
    logic [CNT_WIDTH-1:0]   r_wb;
    logic [CNT_WIDTH-1:0]   r_cb;
    logic                   w_load_shadow;
    logic [LW-1:0]          w_load_idx;
    logic [2*CNT_WIDTH-1:0] r_cfg [LAYER_NUM];

    assign w_num_clamp = (cfg_layer_num > LAYER_MAX) ? LAYER_MAX : cfg_layer_num;
    // Saturating increment; the target compare always exits before the ceiling matters.
    assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_next        = r_state;
        w_idx_next    = r_idx;
        w_latch_num   = 1'b0;
        w_cnt_en      = 1'b0;
        w_load_shadow = 1'b0;
        w_load_idx    = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (cfg_layer_num != '0) begin
                        w_next        = LOAD_W;
                        w_idx_next    = '0;
                        w_latch_num   = 1'b1;
                        w_load_shadow = 1'b1;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            LOAD_W: begin
                w_cnt_en = DDR_valid_in;
                if ((r_wb == '0) || (DDR_valid_in && (w_cnt_inc == r_wb))) begin
                    w_next = LOAD_B;
                end
            end
            LOAD_B: begin
                w_cnt_en = 1'b1;
                if (r_cnt == BIAS_LAST) begin
                    w_next = COMPUTE;
                end
            end
            COMPUTE: begin
                w_cnt_en = MAC_data_valid_out;
                if ((r_cb == '0) || (MAC_data_valid_out && (w_cnt_inc == r_cb))) begin
                    w_next = NEXT;
                end
            end
            NEXT: begin
                if ({1'b0, r_idx} == (r_num - 1'b1)) begin
                    w_next = DONE;
                end else begin
                    w_next        = LOAD_W;
                    w_idx_next    = r_idx + 1'b1;
                    w_load_shadow = 1'b1;
                    w_load_idx    = r_idx + 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // Abort overrides every transition except in IDLE, where start keeps priority.
        if (abort && (r_state != IDLE)) begin
            w_next        = IDLE;
            w_idx_next    = r_idx;
            w_latch_num   = 1'b0;
            w_load_shadow = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_state_rst <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_idx       <= '0;
            r_num       <= '0;
            r_cnt       <= '0;
            r_wb        <= '0;
            r_cb        <= '0;
            for (int i = 0; i < LAYER_NUM; i++) begin
                r_cfg[i] <= '0;
            end
        end else begin
            r_state     <= w_next;
            r_state_rst <= (w_next != r_state);
            r_busy      <= (w_next != IDLE);
            r_done      <= (w_next == DONE);
            r_idx       <= w_idx_next;
            if (w_latch_num) begin
                r_num <= w_num_clamp;
            end
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_cnt_en) begin
                r_cnt <= w_cnt_inc;
            end
            // Table read and table write share the edge, so the shadow sees the old entry.
            if (w_load_shadow) begin
                {r_wb, r_cb} <= r_cfg[w_load_idx];
            end
            if (cfg_wr_en && ({1'b0, cfg_wr_addr} < LAYER_MAX)) begin
                r_cfg[cfg_wr_addr] <= cfg_wr_data;
            end
        end
    end

    assign current_state = r_state;
    assign state_rst     = r_state_rst;
    assign layer_idx     = r_idx;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
